// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and helpers for the sequential ALU.
//   alu_op_e    - operation codes (4-bit)
//   alu_state_e - control FSM states
//   alu_seq_is_legal / alu_seq_is_multicycle - op classification helpers
// Build option: ALU_SEQ_MUL_EN enables the MUL op code (1001).
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_NOT = 4'b0101,
    OP_SLL = 4'b0110,
    OP_SRL = 4'b0111,
    OP_SRA = 4'b1000,
    OP_MUL = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Wide enough for the shift amount of the largest legal WIDTH (64).
  localparam int unsigned AMT_MAX_W = 7;

  function automatic logic alu_seq_is_legal(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
    return op <= OP_MUL;
`else
    return op < OP_MUL;
`endif
  endfunction

  // Shifts by a nonzero amount (and MUL when enabled) iterate in RUN;
  // everything else, including illegal codes, completes in one cycle.
  function automatic logic alu_seq_is_multicycle(input logic [3:0] op,
                                                 input logic [AMT_MAX_W-1:0] amt);
    case (op)
      OP_SLL, OP_SRL, OP_SRA: return amt != '0;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:                 return 1'b1;
`endif
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// alu_seq_core: combinational single-cycle datapath of the sequential ALU.
// Ports:
//   op     in  [3:0]       operation code (ADD/SUB/AND/OR/XOR/NOT handled)
//   a, b   in  [WIDTH-1:0] operands
//   result out [WIDTH-1:0] single-cycle result
//   carry  out             carry (ADD), no-borrow (SUB), 0 otherwise
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // a + ~b + 1: the carry out is set exactly when no borrow occurs.
  assign diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: parametrised multi-cycle ALU with start/done handshake.
// Ports:
//   clk, rst (async, active-high)
//   start, op[3:0], a, b  - request; captured when not busy
//   busy                  - iterative operation in progress
//   done                  - one-cycle completion pulse
//   result, carry, zero, sign, illegal - registered, updated with done
// Build option: ALU_SEQ_MUL_EN adds the shift-add multiplier (op 1001);
// without it 1001 is illegal and the iteration counter is $clog2(WIDTH) bits.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign,
  output logic             illegal
);

  localparam int unsigned AW = $clog2(WIDTH);
`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned CW = AW + 1;  // must hold WIDTH itself
`else
  localparam int unsigned CW = AW;
`endif

  alu_state_e       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] sh_q, sh_d;        // shift operand; multiplicand for MUL
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic             illegal_q, illegal_d;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d;    // {partial high, remaining multiplier}
  logic [WIDTH:0]     mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, sh_q} : '0);
`endif

  logic [AW-1:0]    amt;
  logic             is_shift;
  logic [WIDTH-1:0] core_result;
  logic             core_carry;

  logic             commit;
  logic [WIDTH-1:0] commit_res;
  logic             commit_carry;
  logic             commit_ill;
  logic             bit_out;

  assign amt      = b[AW-1:0];
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (core_result),
    .carry  (core_carry)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d        = acc_q;
`endif
    commit       = 1'b0;
    commit_res   = '0;
    commit_carry = 1'b0;
    commit_ill   = 1'b0;
    bit_out      = 1'b0;

    case (state_q)
      ST_RUN: begin
        cnt_d = cnt_q - CW'(1);
        case (op_q)
          OP_SLL: begin
            bit_out = sh_q[WIDTH-1];
            sh_d    = {sh_q[WIDTH-2:0], 1'b0};
          end
          OP_SRL: begin
            bit_out = sh_q[0];
            sh_d    = {1'b0, sh_q[WIDTH-1:1]};
          end
          OP_SRA: begin
            // MSB never changes, so re-copying it replicates the original sign.
            bit_out = sh_q[0];
            sh_d    = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
          end
`ifdef ALU_SEQ_MUL_EN
          OP_MUL: acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`endif
          default: ;
        endcase
        if (cnt_q == CW'(1)) begin
          state_d      = ST_DONE;
          commit       = 1'b1;
          commit_res   = sh_d;
          commit_carry = bit_out;
`ifdef ALU_SEQ_MUL_EN
          if (op_q == OP_MUL) begin
            commit_res   = acc_d[WIDTH-1:0];
            commit_carry = |acc_d[2*WIDTH-1:WIDTH];
          end
`endif
        end
      end
      default: begin  // ST_IDLE, ST_DONE
        if (start) begin
          op_d = op;
          sh_d = a;
`ifdef ALU_SEQ_MUL_EN
          acc_d = {{WIDTH{1'b0}}, b};
`endif
          if (alu_seq_is_multicycle(op, AMT_MAX_W'(amt))) begin
            state_d = ST_RUN;
            cnt_d   = CW'(amt);
`ifdef ALU_SEQ_MUL_EN
            if (op == OP_MUL) cnt_d = CW'(WIDTH);
`endif
          end else begin
            state_d = ST_DONE;
            commit  = 1'b1;
            if (!alu_seq_is_legal(op)) begin
              commit_ill = 1'b1;
            end else if (is_shift) begin
              commit_res = a;  // shift by zero
            end else begin
              commit_res   = core_result;
              commit_carry = core_carry;
            end
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    sign_d    = sign_q;
    illegal_d = illegal_q;
    if (commit) begin
      result_d  = commit_res;
      carry_d   = commit_carry;
      zero_d    = (commit_res == '0);
      sign_d    = commit_res[WIDTH-1];
      illegal_d = commit_ill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
`ifdef ALU_SEQ_MUL_EN
      acc_q     <= '0;
`endif
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      sign_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q     <= acc_d;
`endif
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      sign_q    <= sign_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign result  = result_q;
  assign carry   = carry_q;
  assign zero    = zero_q;
  assign sign    = sign_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=32), directed and
// randomized requests checked against an arithmetic reference model.
module tb_alu_seq;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic        carry, zero, sign, illegal;

  int total = 0;
  int bad   = 0;

  // Last completed outputs as predicted by the model.
  logic [31:0] exp_res_q = '0;
  logic        exp_c_q   = 1'b0;
  logic        exp_ill_q = 1'b0;

  alu_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .carry   (carry),
    .zero    (zero),
    .sign    (sign),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic c, output logic ill,
                       output int lat);
    logic [63:0] t;
    int n;
    n   = int'(y[4:0]);
    r   = '0;
    c   = 1'b0;
    ill = 1'b0;
    lat = 1;
    case (o)
      4'd0: begin t = 64'(x) + 64'(y); r = t[31:0]; c = t[32]; end
      4'd1: begin r = x - y; c = (x >= y); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = ~x;
      4'd6: begin t = 64'(x) << n; r = t[31:0]; c = t[32]; lat = n + 1; end
      4'd7: begin t = {x, 32'h0} >> n; r = t[63:32]; c = t[31]; lat = n + 1; end
      4'd8: begin t = $signed({x, 32'h0}) >>> n; r = t[63:32]; c = t[31]; lat = n + 1; end
      4'd9: begin
        if (MUL_EN) begin
          t = 64'(x) * 64'(y); r = t[31:0]; c = (t[63:32] != 0); lat = 33;
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
  endtask

  // Issue one request at a negedge; optionally pulse a stray ADD 1+1 start
  // on cycle 'inj' while the operation is running.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int inj);
    logic [31:0] er;
    logic        ec, eill;
    int          lat, k, bc, herr;
    bit          got;
    model(o, x, y, er, ec, eill, lat);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    k = 0; bc = 0; herr = 0; got = 1'b0;
    while (!got && k < 100) begin
      @(negedge clk);
      k++;
      if (inj > 0 && k == inj) begin start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1; end
      if (inj > 0 && k == inj + 1) start = 1'b0;
      if (busy && done) herr++;
      if (done) got = 1'b1;
      else begin
        if (busy) bc++;
        if (result !== exp_res_q || carry !== exp_c_q || illegal !== exp_ill_q) herr++;
      end
    end
    check({tag, ":timeout"}, 64'(got), 64'd1);
    check({tag, ":latency"}, 64'(k), 64'(lat));
    check({tag, ":busy_cycles"}, 64'(bc), 64'(lat - 1));
    check({tag, ":hold"}, 64'(herr), 64'd0);
    check({tag, ":result"}, 64'(result), 64'(er));
    check({tag, ":carry"}, 64'(carry), 64'(ec));
    check({tag, ":zero"}, 64'(zero), 64'(er == 32'd0));
    check({tag, ":sign"}, 64'(sign), 64'(er[31]));
    check({tag, ":illegal"}, 64'(illegal), 64'(eill));
    exp_res_q = er; exp_c_q = ec; exp_ill_q = eill;
    start = 1'b0;
    @(negedge clk);
    check({tag, ":done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int nd;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:done", 64'(done), 64'd0);
    check("rst:result", 64'(result), 64'd0);
    check("rst:flags", 64'({carry, zero, sign, illegal}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sub_neg", 4'd1, 32'd5, 32'd7, 0);
    run_op("sra7", 4'd8, 32'hFFFC_1FFF, 32'd7, 0);
    run_op("srl7", 4'd7, 32'hFFFC_1FFF, 32'd7, 0);
    run_op("sll0", 4'd6, 32'h8000_0001, 32'd0, 0);
    run_op("illegal_f", 4'd15, 32'h1234, 32'h5678, 0);
    run_op("mul_big", 4'd9, 32'h0001_0000, 32'h0001_0000, 0);
    run_op("srl_ignore", 4'd7, 32'hFFFC_1FFF, 32'd7, 3);

    for (int unsigned i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      run_op("rand", 4'($urandom_range(0, 15)), ra, rb, 0);
    end

    // Back-to-back: start held through the DONE cycle of the first op.
    op = 4'd0; a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    op = 4'd4; a = 32'hF0; b = 32'hFF;
    @(negedge clk);
    check("b2b:done1", 64'(done), 64'd1);
    check("b2b:result1", 64'(result), 64'd2);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b:done2", 64'(done), 64'd1);
    check("b2b:result2", 64'(result), 64'h0F);
    check("b2b:carry2", 64'(carry), 64'd0);
    @(negedge clk);
    check("b2b:done_end", 64'(done), 64'd0);

    // Reset mid-operation, with nonzero outputs beforehand.
    run_op("add_ff", 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    if (MUL_EN) begin op = 4'd9; a = 32'h0001_0000; b = 32'h0001_0000; end
    else begin op = 4'd7; a = 32'hFFFF_FFFF; b = 32'd31; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst:busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst:busy", 64'(busy), 64'd0);
    check("midrst:done", 64'(done), 64'd0);
    check("midrst:result", 64'(result), 64'd0);
    check("midrst:flags", 64'({carry, zero, sign, illegal}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check("midrst:no_done", 64'(nd), 64'd0);
    exp_res_q = '0; exp_c_q = 1'b0; exp_ill_q = 1'b0;
    run_op("add_after_rst", 4'd0, 32'd1, 32'd1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
